// File: rtl/qpu_ifu_ibuf_pkg.sv
// qpu_ifu_ibuf_pkg
//   Shared configuration for the IFU instruction buffer.
//   - Default widths, used when the core-wide defines are not already present.
//   - Default buffer depth (`QPU_IBUF_DEPTH).
//   - Entry packing helper. Fields are packed MSB..LSB as
//     {prdt_taken, rs2idx, rs1idx, pc_vld, pc, ir}.
//   Optional feature macro used by qpu_ifu_ibuf: QPU_IBUF_BYPASS_EN.

`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_RFIDX_WIDTH
`define QPU_RFIDX_WIDTH 5
`endif
`ifndef QPU_IBUF_DEPTH
`define QPU_IBUF_DEPTH 4
`endif

package qpu_ifu_ibuf_pkg;

  localparam int IBUF_DEPTH   = `QPU_IBUF_DEPTH;
  localparam int IBUF_INSTR_W = `QPU_INSTR_SIZE;
  localparam int IBUF_PC_W    = `QPU_PC_SIZE;
  localparam int IBUF_RFIDX_W = `QPU_RFIDX_WIDTH;

  // Width of one stored entry: ir + pc + pc_vld + rs1idx + rs2idx + prdt_taken.
  function automatic int ibuf_entry_w(input int instr_w, input int pc_w, input int rfidx_w);
    return instr_w + pc_w + 2 * rfidx_w + 2;
  endfunction

endpackage

// File: rtl/qpu_ifu_ibuf_ram.sv
// qpu_ibuf_ram
//   DEPTH x WIDTH register array for the instruction buffer.
//   One synchronous write port, one asynchronous read port. Contents are not
//   reset; the owner tracks which entries are valid.
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  data at raddr (combinational)

module qpu_ibuf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The head entry must be visible in the same cycle the pointer moves to it.
  assign rdata = mem[raddr];

endmodule

// File: rtl/qpu_ifu_ibuf.sv
// qpu_ifu_ibuf
//   Instruction buffer between the IFU IR stage and EXU dispatch. Holds up to
//   DEPTH instructions with their PC / register-index / prediction sideband,
//   strict FIFO order. A flush empties the buffer in one cycle.
// Optional feature: define QPU_IBUF_BYPASS_EN to let an instruction pass
//   combinationally from i_* to o_* when the buffer is empty and the EXU is
//   ready; such an entry is never written. Without the macro there is no
//   combinational i_* -> o_* path.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   i_valid / i_ready    IFU-side handshake
//   i_ir, i_pc, i_pc_vld, i_rs1idx, i_rs2idx, i_prdt_taken   incoming entry
//   o_valid / o_ready    EXU-side handshake
//   o_ir, o_pc, o_pc_vld, o_rs1idx, o_rs2idx, o_prdt_taken   head entry
//   flush                discard every entry; blocks both handshakes
//   o_count              occupancy, 0..DEPTH

module qpu_ifu_ibuf
  import qpu_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int INSTR_W = IBUF_INSTR_W,
  parameter int PC_W    = IBUF_PC_W,
  parameter int RFIDX_W = IBUF_RFIDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [INSTR_W-1:0]       i_ir,
  input  logic [PC_W-1:0]          i_pc,
  input  logic                     i_pc_vld,
  input  logic [RFIDX_W-1:0]       i_rs1idx,
  input  logic [RFIDX_W-1:0]       i_rs2idx,
  input  logic                     i_prdt_taken,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [INSTR_W-1:0]       o_ir,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_pc_vld,
  output logic [RFIDX_W-1:0]       o_rs1idx,
  output logic [RFIDX_W-1:0]       o_rs2idx,
  output logic                     o_prdt_taken,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ibuf_entry_w(INSTR_W, PC_W, RFIDX_W);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic          active;
  logic          fifo_valid;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic [EW-1:0] head_entry;

  // Reset and flush both suppress every handshake in the current cycle.
  assign active     = rst_n & ~flush;
  assign fifo_valid = active & (count_reg != '0);
  // Full refuses a push even if a pop happens in the same cycle.
  assign i_ready    = active & (count_reg != FULL_COUNT);

  assign wr_entry = {i_prdt_taken, i_rs2idx, i_rs1idx, i_pc_vld, i_pc, i_ir};

`ifdef QPU_IBUF_BYPASS_EN
  logic bypass;
  // Empty buffer and a ready consumer: hand the input straight through and
  // skip the storage so the count stays at zero.
  assign bypass     = active & (count_reg == '0) & i_valid & o_ready;
  assign push       = i_valid & i_ready & ~bypass;
  assign o_valid    = fifo_valid | bypass;
  assign head_entry = bypass ? wr_entry : rd_entry;
`else
  assign push       = i_valid & i_ready;
  assign o_valid    = fifo_valid;
  assign head_entry = rd_entry;
`endif

  assign pop = fifo_valid & o_ready;

  assign {o_prdt_taken, o_rs2idx, o_rs1idx, o_pc_vld, o_pc, o_ir} = head_entry;
  assign o_count = count_reg;

  qpu_ibuf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule
